// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: a phase accumulator makes the Rx oversample
// tick and the Tx bit tick is derived from it. Optional macro: BAUD_GEN_RESYNC_EN.
module baud_gen_frac #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BAUD_DEFAULT = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter logic [ACC_WIDTH-1:0] INC_RESET = ACC_WIDTH'(
    ((64'(BAUD_DEFAULT) * 64'(OVERSAMPLE) << ACC_WIDTH) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ)),
  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] inc_in,
  input  logic                 inc_load,
`ifdef BAUD_GEN_RESYNC_EN
  input  logic                 rx_resync,
`endif
  output logic [ACC_WIDTH-1:0] inc_cur,
  output logic                 Rxclk_en,
  output logic                 Txclk_en,
  output logic [OS_W-1:0]      os_phase
);

  localparam logic [ACC_WIDTH-1:0] ACC_HALF = ACC_WIDTH'(1) << (ACC_WIDTH - 1);
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 os_wrap;

  // The add always uses the increment held at the start of the cycle, so a
  // reprogram never affects the step already in flight.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, inc_cur};
    carry   = sum[ACC_WIDTH];
    os_wrap = (os_phase == OS_LAST);
  end

  // inc_load is a bare one-cycle strobe with no ready: inc_in is sampled on
  // every edge where inc_load=1 and rst=0, regardless of en.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      acc      <= '0;
      os_phase <= '0;
      inc_cur  <= INC_RESET;
      Rxclk_en <= 1'b0;
      Txclk_en <= 1'b0;
    end else begin
      if (inc_load) inc_cur <= inc_in;
`ifdef BAUD_GEN_RESYNC_EN
      if (rx_resync) begin
        // Half-period preload puts the first tick mid-way through the Rx period.
        acc      <= ACC_HALF;
        os_phase <= '0;
        Rxclk_en <= 1'b0;
        Txclk_en <= 1'b0;
      end else
`endif
      if (en) begin
        acc      <= sum[ACC_WIDTH-1:0];
        Rxclk_en <= carry;
        Txclk_en <= carry && os_wrap;
        if (carry) os_phase <= os_wrap ? '0 : os_phase + OS_W'(1);
      end else begin
        Rxclk_en <= 1'b0;
        Txclk_en <= 1'b0;
      end
    end
  end

`ifndef BAUD_GEN_RESYNC_EN
  logic unused_half;
  assign unused_half = ^ACC_HALF;
`endif

endmodule
